mem_port_arbiter: RTL and testbench
===================================

// Module: mem_port_arbiter
// PURPOSE
//  Shares one single-ported memory between instruction fetch (IF) and the MEM-stage load/store
//  path of the rv32 pipeline. Data accesses have priority; a starvation counter guarantees IF progress.
//  One outstanding transaction at a time; routes read data back to the owner; drives stall_if/stall_mem.
// PARAMETERS
//  ADDR_W      32  address width
//  DATA_W      32  data width; strobe width is DATA_W/8
//  STARVE_MAX  4   consecutive IF losses (1..15) before IF is forced to win
// PORTS
//  clk        in   1         clock, all state on rising edge
//  rst        in   1         synchronous reset, active-high
//  if_req     in   1         fetch request; held stable with if_addr until if_gnt
//  if_addr    in   ADDR_W    fetch address
//  if_gnt     out  1         fetch accepted by memory this cycle
//  if_rvalid  out  1         fetch data valid (1-cycle pulse)
//  if_rdata   out  DATA_W    fetch data
//  d_req      in   1         load/store request; held stable until d_gnt
//  d_we       in   1         1=store (MemRW), 0=load
//  d_addr     in   ADDR_W    data address
//  d_wdata    in   DATA_W    store data
//  d_wstrb    in   DATA_W/8  byte enables for stores
//  d_gnt      out  1         data request accepted this cycle
//  d_rvalid   out  1         load data valid (1-cycle pulse)
//  d_rdata    out  DATA_W    load data
//  mem_req    out  1         request to memory
//  mem_we     out  1         write enable to memory
//  mem_addr   out  ADDR_W    address to memory
//  mem_wdata  out  DATA_W    write data
//  mem_wstrb  out  DATA_W/8  byte strobes (0 on reads)
//  mem_ready  in   1         memory accepts request when mem_req&&mem_ready
//  mem_rvalid in   1         read data valid from memory
//  mem_rdata  in   DATA_W    read data from memory
//  stall_if   out  1         if_req && !if_rvalid (combinational)
//  stall_mem  out  1         d_req && !(d_we ? d_gnt : d_rvalid) (combinational)
// BEHAVIOUR
//  - FSM: IDLE, REQ_IF, REQ_D, WAIT_IF, WAIT_D. Reset -> IDLE, starve_cnt=0; all outputs 0 in IDLE
//    except stall_*, which follow their equations.
//  - IDLE: d_req&&(if_req==0 || starve_cnt<STARVE_MAX) -> REQ_D; else if_req -> REQ_IF; else stay.
//    starve_cnt increments (saturating at STARVE_MAX) on each transition to REQ_D taken while
//    if_req=1; it clears when IF is granted.
//  - REQ_x: mem_req=1, mem_* driven combinationally from owner's inputs. On mem_ready: x_gnt pulse;
//    load/fetch -> WAIT_x; store -> IDLE (store completes at acceptance, no rvalid).
//  - WAIT_x: mem_req=0; on mem_rvalid: x_rvalid=1, x_rdata=mem_rdata same cycle -> IDLE.
//  - Minimum latency: req in IDLE -> gnt next cycle (if mem_ready) -> rvalid >=1 cycle after gnt.
//    One idle bubble after each completion before the next request issues.
//  - Owner is latched at IDLE exit; a req appearing/changing while not owner is ignored until IDLE.
//  - mem_rvalid outside WAIT_x is dropped (not forwarded); if_rdata/d_rdata are 0 unless rvalid.
//  - rst mid-transaction: return to IDLE next edge; outstanding read abandoned; late rvalid dropped.
//  - Simultaneous if_req&&d_req with starve_cnt==STARVE_MAX: IF wins; counter clears on if_gnt.
// CONFIGURATION
//  MEM_ARB_PERF_EN defined: adds outputs perf_conflict[31:0] (IDLE cycles with if_req&&d_req
//  both high) and perf_if_stall[31:0] (cycles stall_if=1); both wrap at 2^32 and reset to 0 on rst.
//  Undefined: ports and counters absent; arbitration behaviour identical.
// TESTING
//  1 Fetch only, mem_ready=1, rvalid 1 cycle after gnt, mem_rdata=0x00500093 -> if_gnt cyc1, if_rvalid cyc2 with 0x00500093.
//  2 Store d_we=1 addr 0x100 wdata 0xDEADBEEF wstrb 0xF -> mem_we=1, d_gnt cyc1, no d_rvalid, IDLE cyc2.
//  3 if_req&&d_req held, STARVE_MAX=4 -> grant order D,D,D,D,IF then D; starve_cnt back to 0.
//  4 Load issued, mem_ready low 3 cycles -> mem_req held with stable addr, d_gnt only on cycle ready=1.
//  5 rst asserted in WAIT_D, mem_rvalid arrives after reset -> d_rvalid stays 0, FSM IDLE, starve_cnt 0.
//  6 PERF_EN: 10 conflict cycles -> perf_conflict=10; rst -> 0.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-ported memory between instruction fetch and the data load/store path.
// Optional performance counters are compiled in when MEM_ARB_PERF_EN is defined.
module mem_port_arbiter #(
  parameter int unsigned ADDR_W     = 32,
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                if_req,
  input  logic [ADDR_W-1:0]   if_addr,
  output logic                if_gnt,
  output logic                if_rvalid,
  output logic [DATA_W-1:0]   if_rdata,
  input  logic                d_req,
  input  logic                d_we,
  input  logic [ADDR_W-1:0]   d_addr,
  input  logic [DATA_W-1:0]   d_wdata,
  input  logic [DATA_W/8-1:0] d_wstrb,
  output logic                d_gnt,
  output logic                d_rvalid,
  output logic [DATA_W-1:0]   d_rdata,
  output logic                mem_req,
  output logic                mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic [DATA_W/8-1:0] mem_wstrb,
  input  logic                mem_ready,
  input  logic                mem_rvalid,
  input  logic [DATA_W-1:0]   mem_rdata,
  output logic                stall_if,
  output logic                stall_mem
`ifdef MEM_ARB_PERF_EN
  ,
  output logic [31:0]         perf_conflict,
  output logic [31:0]         perf_if_stall
`endif
);

  localparam int unsigned STRB_W = DATA_W / 8;
  localparam int unsigned CNT_W  = 4;
  localparam logic [CNT_W-1:0] STARVE_LIM = CNT_W'(STARVE_MAX);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_REQ_IF  = 3'd1;
  localparam logic [2:0] S_REQ_D   = 3'd2;
  localparam logic [2:0] S_WAIT_IF = 3'd3;
  localparam logic [2:0] S_WAIT_D  = 3'd4;

  logic [2:0]       state_q, state_d;
  logic [CNT_W-1:0] starve_q, starve_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      starve_q <= '0;
    end else begin
      state_q  <= state_d;
      starve_q <= starve_d;
    end
  end

  // Next state, starvation tracking and the memory-side mux for the current owner.
  always_comb begin
    state_d   = state_q;
    starve_d  = starve_q;
    if_gnt    = 1'b0;
    if_rvalid = 1'b0;
    if_rdata  = '0;
    d_gnt     = 1'b0;
    d_rvalid  = 1'b0;
    d_rdata   = '0;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    mem_wstrb = '0;

    case (state_q)
      S_IDLE: begin
        if (d_req && (!if_req || (starve_q < STARVE_LIM))) begin
          state_d = S_REQ_D;
          if (if_req) begin
            starve_d = CNT_W'(starve_q + CNT_W'(1));
          end
        end else if (if_req) begin
          state_d = S_REQ_IF;
        end
      end

      S_REQ_IF: begin
        mem_req  = 1'b1;
        mem_addr = if_addr;
        if (mem_ready) begin
          if_gnt   = 1'b1;
          starve_d = '0;
          state_d  = S_WAIT_IF;
        end
      end

      S_REQ_D: begin
        mem_req  = 1'b1;
        mem_we   = d_we;
        mem_addr = d_addr;
        if (d_we) begin
          mem_wdata = d_wdata;
          mem_wstrb = d_wstrb;
        end
        if (mem_ready) begin
          d_gnt   = 1'b1;
          // A store is complete once memory accepts it; only loads wait for data.
          state_d = d_we ? S_IDLE : S_WAIT_D;
        end
      end

      S_WAIT_IF: begin
        if (mem_rvalid) begin
          if_rvalid = 1'b1;
          if_rdata  = mem_rdata;
          state_d   = S_IDLE;
        end
      end

      S_WAIT_D: begin
        if (mem_rvalid) begin
          d_rvalid = 1'b1;
          d_rdata  = mem_rdata;
          state_d  = S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign stall_if  = if_req && !if_rvalid;
  assign stall_mem = d_req && !(d_we ? d_gnt : d_rvalid);

`ifdef MEM_ARB_PERF_EN
  logic [31:0] perf_conflict_q, perf_conflict_d;
  logic [31:0] perf_if_stall_q, perf_if_stall_d;

  always_comb begin
    perf_conflict_d = perf_conflict_q;
    perf_if_stall_d = perf_if_stall_q;
    if ((state_q == S_IDLE) && if_req && d_req) begin
      perf_conflict_d = 32'(perf_conflict_q + 32'd1);
    end
    if (stall_if) begin
      perf_if_stall_d = 32'(perf_if_stall_q + 32'd1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      perf_conflict_q <= '0;
      perf_if_stall_q <= '0;
    end else begin
      perf_conflict_q <= perf_conflict_d;
      perf_if_stall_q <= perf_if_stall_d;
    end
  end

  assign perf_conflict = perf_conflict_q;
  assign perf_if_stall = perf_if_stall_q;
`endif

  logic unused_strb_w;
  assign unused_strb_w = (STRB_W == 0);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: memory responder model, rvalid scoreboard, directed tests.
// Performance counter checks run only when MEM_ARB_PERF_EN is defined.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_gnt, if_rvalid;
  logic [31:0] if_rdata;
  logic        d_req, d_we;
  logic [31:0] d_addr, d_wdata;
  logic [3:0]  d_wstrb;
  logic        d_gnt, d_rvalid;
  logic [31:0] d_rdata;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        mem_ready, mem_rvalid;
  logic [31:0] mem_rdata;
  logic        stall_if, stall_mem;
`ifdef MEM_ARB_PERF_EN
  logic [31:0] perf_conflict, perf_if_stall;
`endif

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .STARVE_MAX(4)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_wstrb(d_wstrb),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_wstrb(mem_wstrb), .mem_ready(mem_ready), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .stall_if(stall_if), .stall_mem(stall_mem)
`ifdef MEM_ARB_PERF_EN
    , .perf_conflict(perf_conflict), .perf_if_stall(perf_if_stall)
`endif
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  logic [31:0] exp_if[$];
  logic [31:0] exp_d[$];
  int          rd_lat = 1;
  int          rv_cnt = 0;
  logic [31:0] rv_data = '0;
  int          mem_rv_seen = 0;

  function automatic logic [31:0] mem_model(input logic [31:0] a);
    if (a == 32'h0) return 32'h0050_0093;
    return {a[15:0], ~a[15:0]} ^ 32'h1357_9BDF;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    int n = 0;
    while ((exp_if.size() != 0 || exp_d.size() != 0) && n < 50) begin
      tick();
      n++;
    end
    check("drain_pending", 32'(exp_if.size() + exp_d.size()), 32'd0);
    repeat (2) tick();
  endtask

  // Memory: accepts when mem_ready, returns read data rd_lat cycles after acceptance.
  initial begin
    logic        hs;
    logic [31:0] hs_addr;
    mem_rvalid = 1'b0;
    mem_rdata  = '0;
    forever begin
      @(negedge clk);
      hs      = mem_req && mem_ready && !mem_we;
      hs_addr = mem_addr;
      @(posedge clk);
      #1;
      mem_rvalid = 1'b0;
      mem_rdata  = '0;
      if (rv_cnt != 0) begin
        rv_cnt--;
        if (rv_cnt == 0) begin
          mem_rvalid = 1'b1;
          mem_rdata  = rv_data;
        end
      end
      if (hs) begin
        if (rd_lat <= 1) begin
          mem_rvalid = 1'b1;
          mem_rdata  = mem_model(hs_addr);
        end else begin
          rv_cnt  = rd_lat - 1;
          rv_data = mem_model(hs_addr);
        end
      end
      if (mem_rvalid) mem_rv_seen++;
    end
  end

  // Scoreboard: every rvalid must match the oldest expected read for that port.
  initial begin
    forever begin
      @(negedge clk);
      if (if_rvalid) begin
        if (exp_if.size() == 0) check("if_rvalid_unexpected", 32'(if_rvalid), 32'd0);
        else check("if_rdata", if_rdata, exp_if.pop_front());
      end
      if (d_rvalid) begin
        if (exp_d.size() == 0) check("d_rvalid_unexpected", 32'(d_rvalid), 32'd0);
        else check("d_rdata", d_rdata, exp_d.pop_front());
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog_timeout got=running exp=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] exp_seq [6];
    logic [7:0] got_g;
    int         ng;
    int         seen;
    logic       drop;
    exp_seq = '{8'h44, 8'h44, 8'h44, 8'h44, 8'h49, 8'h44};

    rst = 1'b1; if_req = 1'b0; if_addr = '0;
    d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0; d_wstrb = '0;
    mem_ready = 1'b1;
    repeat (2) tick();
    @(negedge clk);
    check("rst_mem_req", 32'(mem_req), 32'd0);
    check("rst_if_gnt", 32'(if_gnt), 32'd0);
    check("rst_d_gnt", 32'(d_gnt), 32'd0);
    check("rst_mem_wstrb", 32'(mem_wstrb), 32'd0);
    check("rst_if_rdata", if_rdata, 32'd0);
    check("rst_state", 32'(dut.state_q), 32'd0);
    check("rst_starve", 32'(dut.starve_q), 32'd0);
    tick();
    rst = 1'b0;

    // Fetch only
    if_req = 1'b1; if_addr = 32'h0;
    exp_if.push_back(32'h0050_0093);
    @(negedge clk);
    check("t1_stall_if_c0", 32'(stall_if), 32'd1);
    check("t1_gnt_c0", 32'(if_gnt), 32'd0);
    tick();
    @(negedge clk);
    check("t1_if_gnt_c1", 32'(if_gnt), 32'd1);
    check("t1_mem_req_c1", 32'(mem_req), 32'd1);
    check("t1_mem_we_c1", 32'(mem_we), 32'd0);
    tick();
    if_req = 1'b0;
    @(negedge clk);
    check("t1_if_rvalid_c2", 32'(if_rvalid), 32'd1);
    check("t1_if_rdata_c2", if_rdata, 32'h0050_0093);
    tick();
    drain();

    // Store
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h100; d_wdata = 32'hDEAD_BEEF; d_wstrb = 4'hF;
    @(negedge clk);
    check("t2_stall_mem_c0", 32'(stall_mem), 32'd1);
    tick();
    @(negedge clk);
    check("t2_d_gnt_c1", 32'(d_gnt), 32'd1);
    check("t2_mem_we_c1", 32'(mem_we), 32'd1);
    check("t2_mem_addr_c1", mem_addr, 32'h100);
    check("t2_mem_wdata_c1", mem_wdata, 32'hDEAD_BEEF);
    check("t2_mem_wstrb_c1", 32'(mem_wstrb), 32'hF);
    check("t2_stall_mem_c1", 32'(stall_mem), 32'd0);
    tick();
    d_req = 1'b0;
    @(negedge clk);
    check("t2_d_rvalid_c2", 32'(d_rvalid), 32'd0);
    check("t2_state_c2", 32'(dut.state_q), 32'd0);
    check("t2_mem_req_c2", 32'(mem_req), 32'd0);
    drain();

    // Starvation: both requesting, D wins until the counter saturates
    if_req = 1'b1; if_addr = 32'h40;
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h80; d_wdata = 32'h1234_5678; d_wstrb = 4'h3;
    exp_if.push_back(mem_model(32'h40));
    ng = 0; drop = 1'b0;
    for (int c = 0; c < 60 && ng < 6; c++) begin
      @(negedge clk);
      if (d_gnt || if_gnt) begin
        got_g = if_gnt ? 8'h49 : 8'h44;
        check($sformatf("t3_grant%0d", ng), 32'(got_g), 32'(exp_seq[ng]));
        if (if_gnt) begin
          check("t3_starve_at_if_gnt", 32'(dut.starve_q), 32'd4);
          drop = 1'b1;
        end
        ng++;
      end
      tick();
      if (drop) if_req = 1'b0;
    end
    check("t3_grant_count", 32'(ng), 32'd6);
    check("t3_starve_end", 32'(dut.starve_q), 32'd0);
    d_req = 1'b0;
    drain();

    // Load with memory back-pressure
    rd_lat = 3;
    mem_ready = 1'b0;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h344; d_wstrb = 4'hF;
    exp_d.push_back(mem_model(32'h344));
    tick();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check($sformatf("t4_mem_req_w%0d", i), 32'(mem_req), 32'd1);
      check($sformatf("t4_mem_addr_w%0d", i), mem_addr, 32'h344);
      check($sformatf("t4_d_gnt_w%0d", i), 32'(d_gnt), 32'd0);
      tick();
    end
    mem_ready = 1'b1;
    @(negedge clk);
    check("t4_d_gnt_ready", 32'(d_gnt), 32'd1);
    check("t4_mem_wstrb_load", 32'(mem_wstrb), 32'd0);
    check("t4_stall_mem_gnt", 32'(stall_mem), 32'd1);
    tick();
    d_req = 1'b0;
    drain();

    // Reset while waiting for load data; the late response must be dropped
    rd_lat = 6;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h300;
    tick();
    @(negedge clk);
    check("t5_d_gnt", 32'(d_gnt), 32'd1);
    tick();
    d_req = 1'b0;
    @(negedge clk);
    check("t5_state_wait_d", 32'(dut.state_q), 32'd4);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    @(negedge clk);
    check("t5_state_after_rst", 32'(dut.state_q), 32'd0);
    check("t5_starve_after_rst", 32'(dut.starve_q), 32'd0);
    mem_rv_seen = 0;
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      @(negedge clk);
      if (d_rvalid) seen++;
    end
    check("t5_late_d_rvalid", 32'(seen), 32'd0);
    check("t5_late_mem_rvalid_seen", 32'(mem_rv_seen), 32'd1);
    check("t5_state_end", 32'(dut.state_q), 32'd0);
    rd_lat = 1;
    tick();
    drain();

`ifdef MEM_ARB_PERF_EN
    // Conflict counter: every grant below leaves an IDLE cycle with both requests high
    rst = 1'b1;
    tick();
    @(negedge clk);
    check("t6_conflict_rst", perf_conflict, 32'd0);
    tick();
    rst = 1'b0;
    if_req = 1'b1; if_addr = 32'h60;
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h90; d_wstrb = 4'hF;
    ng = 0;
    for (int c = 0; c < 100 && ng < 10; c++) begin
      @(negedge clk);
      if (if_gnt) exp_if.push_back(mem_model(32'h60));
      if (if_gnt || d_gnt) ng++;
      tick();
    end
    if_req = 1'b0;
    d_req = 1'b0;
    drain();
    check("t6_grants", 32'(ng), 32'd10);
    check("t6_conflict", perf_conflict, 32'd10);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    @(negedge clk);
    check("t6_conflict_clear", perf_conflict, 32'd0);
    check("t6_if_stall_clear", perf_if_stall, 32'd0);
    tick();
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
